sysid_probe_master: RTL
=======================

// Module: sysid_probe_master
// PURPOSE
//  Avalon-MM read initiator that interrogates a system-ID responder.
//  On start it issues two single-word reads: word 0 (ID), then word 1 (timestamp).
//  It compares each result against the expected values and reports pass/fail
//  and timeout status to boot/health logic.
//  Sits between the boot sequencer and the interconnect, on the sysid control_slave.
// PARAMETERS
//  EXPECTED_ID     32'h0000_0000  value required at word address 0
//  EXPECTED_TS     32'h5E6B_2050  value required at word address 1 (1584078928)
//  TIMEOUT_CYCLES  16             max cycles per read, from assertion of read to readdatavalid
//  MAX_RETRIES     2              re-issues of a timed-out read before giving up (0..7)
// PORTS
//  clock          in   1   single clock; all logic rising-edge
//  reset          in   1   synchronous, active-high
//  start          in   1   pulse; accepted only in IDLE
//  address        out  1   Avalon word address (0=ID, 1=timestamp)
//  read           out  1   Avalon read request
//  waitrequest    in   1   interconnect stall; request held while high
//  readdata       in   32  Avalon read data
//  readdatavalid  in   1   qualifies readdata
//  busy           out  1   high from accepted start until done
//  done           out  1   one-cycle pulse at end of sequence
//  id_ok          out  1   sticky until next start: ID matched
//  ts_ok          out  1   sticky until next start: timestamp matched
//  timeout        out  1   sticky until next start: retries exhausted
//  id_value       out  32  last captured ID word
//  ts_value       out  32  last captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-sequence aborts at once;
//   no done pulse.
//  FSM: IDLE -> ID_REQ -> ID_WAIT -> TS_REQ -> TS_WAIT -> FINISH -> IDLE.
//  IDLE
//   - start=1: clear id_ok/ts_ok/timeout/values, go ID_REQ.
//   - start in any other state is ignored.
//  *_REQ
//   - read=1 with address held stable.
//   - The request is accepted on the first cycle with waitrequest=0, then go *_WAIT.
//   - read is never high outside *_REQ.
//  *_WAIT
//   - read=0. On readdatavalid=1, capture readdata into *_value.
//   - Set *_ok = (readdata == EXPECTED_*), then advance.
//   - readdatavalid is also accepted in the acceptance cycle itself (zero-latency
//     responder); the FSM then skips *_WAIT.
//  Timeout
//   - A per-read cycle counter starts at the first read assertion and counts
//     through REQ and WAIT.
//   - Reaching TIMEOUT_CYCLES without data: if retry count < MAX_RETRIES,
//     increment it and return to the same *_REQ.
//   - Otherwise set timeout=1 and go FINISH. The remaining read is skipped and its
//     *_ok stays 0.
//   - Retry count resets per word.
//  Data in the same cycle as expiry is taken as valid; the timeout is ignored.
//  Stray readdatavalid outside *_WAIT/*_REQ is ignored.
//  FINISH: done=1 for exactly one cycle, busy=0 next cycle, FSM=IDLE.
//  busy=1 in every state except IDLE. Latency with a zero-wait responder:
//   start -> done = 6 cycles.
//  Comparisons are full 32-bit equality; no masking.
// STRUCTURE
//  Shared package sysid_pkg:
//   - FSM state enum (3-bit)
//   - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
//   - default expected-value constants
//  One sub-module, avmm_read_timer:
//   - per-read cycle counter with expiry flag and retry counter
//   - inputs clear/en; outputs expired, retries_left
//  The FSM and compare logic stay in this module.
// TESTING
//  1 Zero-wait responder returning 0 / 0x5E6B2050 -> id_ok=1, ts_ok=1,
//    timeout=0, done 6 cycles after start.
//  2 waitrequest high 3 cycles on each read -> address/read stable throughout;
//    single read per word; both ok.
//  3 Word 1 returns 0x5E6B2051 -> id_ok=1, ts_ok=0, ts_value=0x5E6B2051, done=1.
//  4 No readdatavalid on word 0, MAX_RETRIES=2 -> 3 read issues,
//    timeout=1 at ~48 cycles, word 1 never read, done pulses.
//  5 First attempt times out, retry answers -> timeout=0, id_ok=1.
//    Also: start asserted while busy is ignored.
//  6 reset asserted in ID_WAIT -> next cycle read=0, busy=0, all flags 0, no done.
//    A new start then passes.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID probe master.
package sysid_pkg;

   localparam int unsigned SYSID_DATA_W = 32;
   localparam int unsigned SYSID_RTY_W  = 3;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID = 32'h0000_0000;
   localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TS = 32'h5E6B_2050;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ID_REQ  = 3'd1,
      ST_ID_WAIT = 3'd2,
      ST_TS_REQ  = 3'd3,
      ST_TS_WAIT = 3'd4,
      ST_FINISH  = 3'd5
   } sysid_state_e;

   // Word address presented on the bus while in a given state.
   function automatic logic sysid_word_addr(input sysid_state_e s);
      return ((s == ST_TS_REQ) || (s == ST_TS_WAIT)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
   endfunction

endpackage

// File: rtl/avmm_read_timer.sv
// Per-read cycle counter with expiry flag and per-word retry budget.
module avmm_read_timer
   import sysid_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   en,
   input  logic                   retry,
   output logic                   expired,
   output logic [SYSID_RTY_W-1:0] retries_left
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   // Expiry fires in the last permitted cycle of the current read attempt.
   assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // clear starts a new word (full retry budget); retry restarts the cycle count only.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q        <= '0;
         retries_left <= '0;
      end else if (clear) begin
         cnt_q        <= '0;
         retries_left <= SYSID_RTY_W'(MAX_RETRIES);
      end else if (retry) begin
         cnt_q        <= '0;
         retries_left <= retries_left - SYSID_RTY_W'(1);
      end else if (en && !expired) begin
         cnt_q        <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM read initiator that reads and checks the system-ID and timestamp words.
module sysid_probe_master
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
   parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   input  logic        readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   sysid_state_e state_q, state_d;

   logic        address_d, read_d, busy_d, done_d;
   logic        id_ok_d, ts_ok_d, timeout_d;
   logic [31:0] id_value_d, ts_value_d;

   logic                   tmr_clear, tmr_en, tmr_retry, tmr_expired;
   logic [SYSID_RTY_W-1:0] tmr_retries_left;

   logic is_req, is_ts, data_hit;

   assign is_req   = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
   assign is_ts    = (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);
   // Data is taken while waiting, or in the acceptance cycle of a zero-latency responder.
   assign data_hit = readdatavalid && (is_req ? !waitrequest : 1'b1);

   avmm_read_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
   ) u_timer (
      .clock        (clock),
      .reset        (reset),
      .clear        (tmr_clear),
      .en           (tmr_en),
      .retry        (tmr_retry),
      .expired      (tmr_expired),
      .retries_left (tmr_retries_left)
   );

   // Next-state, capture/compare and next-output logic.
   always_comb begin
      state_d    = state_q;
      id_ok_d    = id_ok;
      ts_ok_d    = ts_ok;
      timeout_d  = timeout;
      id_value_d = id_value;
      ts_value_d = ts_value;
      tmr_clear  = 1'b0;
      tmr_en     = 1'b0;
      tmr_retry  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_ID_REQ;
               id_ok_d    = 1'b0;
               ts_ok_d    = 1'b0;
               timeout_d  = 1'b0;
               id_value_d = '0;
               ts_value_d = '0;
               tmr_clear  = 1'b1;
            end
         end
         ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT: begin
            tmr_en = 1'b1;
            if (data_hit) begin
               if (is_ts) begin
                  ts_value_d = readdata;
                  ts_ok_d    = (readdata == EXPECTED_TS);
                  state_d    = ST_FINISH;
               end else begin
                  id_value_d = readdata;
                  id_ok_d    = (readdata == EXPECTED_ID);
                  state_d    = ST_TS_REQ;
                  tmr_clear  = 1'b1;
               end
            end else if (tmr_expired) begin
               if (tmr_retries_left != '0) begin
                  tmr_retry = 1'b1;
                  state_d   = is_ts ? ST_TS_REQ : ST_ID_REQ;
               end else begin
                  timeout_d = 1'b1;
                  state_d   = ST_FINISH;
               end
            end else if (is_req && !waitrequest) begin
               state_d = is_ts ? ST_TS_WAIT : ST_ID_WAIT;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      read_d    = (state_d == ST_ID_REQ) || (state_d == ST_TS_REQ);
      address_d = sysid_word_addr(state_d);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_FINISH);
   end

   // State and registered outputs; reset aborts any sequence without a done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         address  <= 1'b0;
         read     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         state_q  <= state_d;
         address  <= address_d;
         read     <= read_d;
         busy     <= busy_d;
         done     <= done_d;
         id_ok    <= id_ok_d;
         ts_ok    <= ts_ok_d;
         timeout  <= timeout_d;
         id_value <= id_value_d;
         ts_value <= ts_value_d;
      end
   end

endmodule
